// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the MDC FFT twiddle stages.
// Contents:
//   DATA_W_DEFAULT  default signed sample width
//   SEG_LEN_DEFAULT default number of valid samples per twiddle index
//   TW_W, TW_FRAC   twiddle word width and fraction bits (Q1.7, 128 = 1.0)
//   TW_ONE, TW_C45  twiddle magnitudes used by the 4-entry ROM
//   tw_idx_e        twiddle index as driven to the ROM select
//   sat()           clamp a wide signed value into a w-bit signed range
package fft_pkg;

  localparam int DATA_W_DEFAULT  = 16;
  localparam int SEG_LEN_DEFAULT = 2;
  localparam int TW_W            = 9;
  localparam int TW_FRAC         = 7;
  localparam int TW_ONE          = 128;
  localparam int TW_C45          = 90;

  // W = 1, (90-j90)/128, -j, (-90-j90)/128
  typedef enum logic [1:0] {
    TW_IDX_ONE  = 2'd0,
    TW_IDX_M45  = 2'd1,
    TW_IDX_MJ   = 2'd2,
    TW_IDX_M135 = 2'd3
  } tw_idx_e;

  // Clamp x to [-2^(w-1), 2^(w-1)-1]; the caller narrows the result to w bits
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    maxV = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (w - 1));
    if (x > maxV)
      sat = maxV;
    else if (x < minV)
      sat = minV;
    else
      sat = x;
  endfunction

endpackage

// File: rtl/fft_cmult.sv
// Complex multiply by a Q1.7 twiddle with rescale and saturation (pipeline
// stages S2 and S3), shared by the MDC twiddle stages.
// Configuration macro: TW_ROUND_EN (round half up before the >>7; otherwise
// truncation toward -inf). Latency is two cycles either way.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   valid_i    sample valid        first_i / last_i  frame flags
//   a_i, b_i   sample real / imag (signed DATA_W)
//   c_i, d_i   twiddle real / imag (signed Q1.7)
//   valid_o    result valid        first_o / last_o  frame flags
//   re_o, im_o saturated result real / imag, zero when valid_o is low
module fft_cmult
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic                     last_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [TW_W-1:0]   c_i,
  input  logic signed [TW_W-1:0]   d_i,
  output logic                     valid_o,
  output logic                     first_o,
  output logic                     last_o,
  output logic signed [DATA_W-1:0] re_o,
  output logic signed [DATA_W-1:0] im_o
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;
  // One extra bit so the rounding offset can never wrap the sum
  localparam int RW = SW + 1;

`ifdef TW_ROUND_EN
  localparam logic signed [RW-1:0] RND = RW'(1 << (TW_FRAC - 1));
`else
  localparam logic signed [RW-1:0] RND = '0;
`endif

  logic signed [PW-1:0]     ac_d, bd_d, ad_d, bc_d;
  logic signed [PW-1:0]     ac_q, bd_q, ad_q, bc_q;
  logic                     s2Valid_q, s2First_q, s2Last_q;
  logic signed [SW-1:0]     reSum, imSum;
  logic signed [RW-1:0]     reRnd, imRnd, reShift, imShift;
  logic signed [DATA_W-1:0] re_d, im_d;
  logic                     valid_q, first_q, last_q;
  logic signed [DATA_W-1:0] re_q, im_q;

  // S2: four partial products at full precision
  always_comb begin
    ac_d = PW'(a_i) * PW'(c_i);
    bd_d = PW'(b_i) * PW'(d_i);
    ad_d = PW'(a_i) * PW'(d_i);
    bc_d = PW'(b_i) * PW'(c_i);
  end

  // S3: combine, optional round, arithmetic rescale, clamp; zero when idle
  always_comb begin
    reSum   = SW'(ac_q) - SW'(bd_q);
    imSum   = SW'(ad_q) + SW'(bc_q);
    reRnd   = RW'(reSum) + RND;
    imRnd   = RW'(imSum) + RND;
    reShift = reRnd >>> TW_FRAC;
    imShift = imRnd >>> TW_FRAC;
    re_d    = '0;
    im_d    = '0;
    if (s2Valid_q) begin
      re_d = DATA_W'(sat(64'(reShift), DATA_W));
      im_d = DATA_W'(sat(64'(imShift), DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_q      <= '0;
      bd_q      <= '0;
      ad_q      <= '0;
      bc_q      <= '0;
      s2Valid_q <= 1'b0;
      s2First_q <= 1'b0;
      s2Last_q  <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      ac_q      <= ac_d;
      bd_q      <= bd_d;
      ad_q      <= ad_d;
      bc_q      <= bc_d;
      s2Valid_q <= valid_i;
      s2First_q <= valid_i & first_i;
      s2Last_q  <= valid_i & last_i;
      valid_q   <= s2Valid_q;
      first_q   <= s2Valid_q & s2First_q;
      last_q    <= s2Valid_q & s2Last_q;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign re_o    = re_q;
  assign im_o    = im_q;

endmodule

// File: rtl/tw_mult_stage4.sv
// Twiddle-multiply stage behind the 4-entry twiddle ROM of the 32-point MDC
// FFT. Owns the segment/index counters that select the ROM entry, registers
// the sample with its twiddle (S1) and hands off to fft_cmult (S2, S3).
// Fixed latency of 3 cycles from in_valid to out_valid, no stalls.
// Configuration macro: TW_ROUND_EN (round half up in fft_cmult).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_first    input strobe and frame start (first needs valid)
//   in_re, in_im          input sample (signed DATA_W)
//   rom_idx               twiddle index for the current sample, to the ROM
//   tw_re, tw_im          ROM twiddle (signed Q1.7), same cycle as the sample
//   out_valid             result strobe
//   out_first, out_last   frame start / frame end flags of the result
//   out_re, out_im        saturated product, zero when out_valid is low
module tw_mult_stage4
  import fft_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int SEG_LEN = SEG_LEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic [1:0]               rom_idx,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im
);

  localparam int SEG_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

  logic [SEG_W-1:0]         seg_q, seg_d, segCur;
  tw_idx_e                  idx_q, idx_d, idxCur;
  logic                     takeFirst, segEnd, lastCur;
  logic                     s1Valid_q, s1First_q, s1Last_q;
  logic signed [DATA_W-1:0] s1Re_q, s1Im_q;
  logic signed [TW_W-1:0]   s1TwRe_q, s1TwIm_q;

  // The counters hold the position of the next sample; a qualified in_first
  // overrides it to the frame start so the current sample and the ROM select
  // both see index 0 in the same cycle.
  always_comb begin
    takeFirst = in_valid & in_first;
    segCur    = takeFirst ? '0 : seg_q;
    idxCur    = takeFirst ? TW_IDX_ONE : idx_q;
    segEnd    = (segCur == SEG_W'(SEG_LEN - 1));
    lastCur   = segEnd && (idxCur == TW_IDX_M135);
    seg_d     = seg_q;
    idx_d     = idx_q;
    if (in_valid) begin
      if (segEnd) begin
        seg_d = '0;
        idx_d = tw_idx_e'(idxCur + 2'd1);
      end else begin
        seg_d = segCur + SEG_W'(1);
        idx_d = idxCur;
      end
    end
  end

  assign rom_idx = idxCur;

  // S1: capture sample, twiddle and frame flags together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= '0;
      idx_q     <= TW_IDX_ONE;
      s1Valid_q <= 1'b0;
      s1First_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Re_q    <= '0;
      s1Im_q    <= '0;
      s1TwRe_q  <= '0;
      s1TwIm_q  <= '0;
    end else begin
      seg_q     <= seg_d;
      idx_q     <= idx_d;
      s1Valid_q <= in_valid;
      s1First_q <= takeFirst;
      s1Last_q  <= in_valid & lastCur;
      s1Re_q    <= in_re;
      s1Im_q    <= in_im;
      s1TwRe_q  <= tw_re;
      s1TwIm_q  <= tw_im;
    end
  end

  fft_cmult #(
    .DATA_W (DATA_W)
  ) u_cmult (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s1Valid_q),
    .first_i (s1First_q),
    .last_i  (s1Last_q),
    .a_i     (s1Re_q),
    .b_i     (s1Im_q),
    .c_i     (s1TwRe_q),
    .d_i     (s1TwIm_q),
    .valid_o (out_valid),
    .first_o (out_first),
    .last_o  (out_last),
    .re_o    (out_re),
    .im_o    (out_im)
  );

endmodule

// File: tb/tb_tw_mult_stage4.sv
// Testbench for tw_mult_stage4 (default DATA_W=16, SEG_LEN=2). Provides the
// combinational twiddle ROM and compares every cycle against a reference
// model of frame position, complex product, rescale and clamping.
// Honours TW_ROUND_EN the same way as the design.
module tb_tw_mult_stage4;

  localparam int DATA_W  = 16;
  localparam int SEG_LEN = 2;
  localparam int FRAME   = 4 * SEG_LEN;

  typedef struct {
    bit     v;
    bit     f;
    bit     l;
    longint re;
    longint im;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid, in_first;
  logic signed [DATA_W-1:0] in_re, in_im;
  logic [1:0]               rom_idx;
  logic signed [8:0]        tw_re, tw_im;
  logic                     out_valid, out_first, out_last;
  logic signed [DATA_W-1:0] out_re, out_im;

  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  exp_t pipe[3];

  tw_mult_stage4 #(
    .DATA_W  (DATA_W),
    .SEG_LEN (SEG_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_re     (in_re),
    .in_im     (in_im),
    .rom_idx   (rom_idx),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  // Twiddle ROM: W = 1, (90-j90)/128, -j, (-90-j90)/128
  always_comb begin
    case (rom_idx)
      2'd0:    begin tw_re = 9'sd128; tw_im = 9'sd0;    end
      2'd1:    begin tw_re = 9'sd90;  tw_im = -9'sd90;  end
      2'd2:    begin tw_re = 9'sd0;   tw_im = -9'sd128; end
      default: begin tw_re = -9'sd90; tw_im = -9'sd90;  end
    endcase
  end

  function automatic longint floorDiv128(input longint p);
    longint q;
    q = p / 128;
    if ((p % 128) != 0 && p < 0)
      q = q - 1;
    return q;
  endfunction

  function automatic longint clamp16(input longint x);
    if (x > 32767)
      return 32767;
    if (x < -32768)
      return -32768;
    return x;
  endfunction

  function automatic exp_t modelMul(input longint a, input longint b, input int idx);
    exp_t   e;
    longint c, d, pr, pi;
    case (idx)
      0:       begin c = 128; d = 0;    end
      1:       begin c = 90;  d = -90;  end
      2:       begin c = 0;   d = -128; end
      default: begin c = -90; d = -90;  end
    endcase
    pr = a * c - b * d;
    pi = a * d + b * c;
`ifdef TW_ROUND_EN
    pr = pr + 64;
    pi = pi + 64;
`endif
    e.v  = 1'b1;
    e.f  = 1'b0;
    e.l  = 1'b0;
    e.re = clamp16(floorDiv128(pr));
    e.im = clamp16(floorDiv128(pi));
    return e;
  endfunction

  function automatic longint rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return longint'(t);
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check the ROM select, then the outputs
  task automatic applyStimulus(input bit rst, input bit v, input bit f,
                               input longint re, input longint im);
    exp_t e;
    int   idx;
    rst_n    = !rst;
    in_valid = v;
    in_first = f;
    in_re    = 16'(re);
    in_im    = 16'(im);
    e = '{v: 1'b0, f: 1'b0, l: 1'b0, re: 0, im: 0};
    @(negedge clk);
    if (rst) begin
      pos = 0;
    end else if (v) begin
      if (f)
        pos = 0;
      idx = pos / SEG_LEN;
      checkOutput("rom_idx", rom_idx, idx);
      e   = modelMul(re, im, idx);
      e.f = f;
      e.l = (pos == FRAME - 1);
      pos = (pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 3; k++)
        pipe[k] = '{v: 1'b0, f: 1'b0, l: 1'b0, re: 0, im: 0};
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
    end
    checkOutput("out_valid", out_valid, pipe[2].v);
    checkOutput("out_first", out_first, pipe[2].f);
    checkOutput("out_last",  out_last,  pipe[2].l);
    checkOutput("out_re",    out_re,    pipe[2].re);
    checkOutput("out_im",    out_im,    pipe[2].im);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_re    = '0;
    in_im    = '0;
    for (int k = 0; k < 3; k++)
      pipe[k] = '{v: 1'b0, f: 1'b0, l: 1'b0, re: 0, im: 0};

    // Reset held with in_valid high, then idle cycles must stay all zero
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, rnd16(), rnd16());
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);

    // Index sweep with (100,0)
    for (int i = 0; i < FRAME; i++)
      applyStimulus(0, 1, i == 0, 100, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);

    // Saturation corners across all four twiddles
    applyStimulus(0, 1, 1, -32768, -32768);
    applyStimulus(0, 1, 0, 32767, -32768);
    applyStimulus(0, 1, 0, 32767, 32767);
    applyStimulus(0, 1, 0, -32768, 32767);
    applyStimulus(0, 1, 0, -32768, -32768);
    applyStimulus(0, 1, 0, 0, -32768);
    applyStimulus(0, 1, 0, -32768, -32768);
    applyStimulus(0, 1, 0, 32767, 32767);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);

    // Gaps then a mid-frame resync
    for (int i = 0; i < 8; i++)
      applyStimulus(0, (i % 2) == 0, 0, rnd16(), rnd16());
    applyStimulus(0, 1, 1, rnd16(), rnd16());
    for (int i = 0; i < 10; i++)
      applyStimulus(0, (i % 2) == 1, 0, rnd16(), rnd16());

    // Randomized traffic with occasional frame starts
    for (int i = 0; i < 80; i++) begin
      bit v, f;
      v = ($urandom_range(0, 3) != 0);
      f = v && ($urandom_range(0, 9) == 0);
      applyStimulus(0, v, f, rnd16(), rnd16());
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);

    // Reset after 5 valids drops in-flight samples; next frame restarts at 0
    applyStimulus(0, 1, 1, rnd16(), rnd16());
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, rnd16(), rnd16());
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < FRAME; i++)
      applyStimulus(0, 1, 0, rnd16(), rnd16());
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
